// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial two-input gate bank with valid/ready handshakes.
// Latches one operand pair and opcode, evaluates the selected gate one bit
// per cycle (LSB first), then holds the W-bit result until it is accepted.
// Optional feature macro: SLU_PARITY_EN adds a registered parity output (^y).
module serial_logic_unit #(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [w-1:0] a,
   input  logic [w-1:0] b,
   input  logic [2:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [w-1:0] y,
   output logic         err,
   output logic         busy
`ifdef SLU_PARITY_EN
   ,
   output logic         parity
`endif
);

   localparam int CW = (w > 1) ? $clog2(w) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   logic [w-1:0]   a_q;
   logic [w-1:0]   b_q;
   logic [w-1:0]   sr;
   logic [2:0]     op_q;
   logic [CW-1:0]  cnt;
   logic           bit_res;
   logic           reserved;

   // Gate applied to the current operand LSBs; reserved opcodes yield 0
   always_comb begin
      bit_res = 1'b0;
      case (op_q)
         3'b000:  bit_res = a_q[0] & b_q[0];
         3'b001:  bit_res = a_q[0] | b_q[0];
         3'b010:  bit_res = a_q[0] ^ b_q[0];
         3'b011:  bit_res = ~(a_q[0] & b_q[0]);
         3'b100:  bit_res = ~(a_q[0] | b_q[0]);
         default: bit_res = 1'b0;
      endcase
   end

   assign reserved = (op_q > 3'b100);

   // Control FSM with registered handshake/status outputs and datapath shift
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sr        <= '0;
         op_q      <= '0;
         cnt       <= '0;
         y         <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
`ifdef SLU_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op;
                  cnt      <= '0;
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               a_q <= a_q >> 1;
               b_q <= b_q >> 1;
               sr  <= {bit_res, sr[w-1:1]};
               if (cnt == CW'(w - 1)) begin
                  // Terminal count is explicit; the counter is parked at zero
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (!out_valid) begin
                  // First DONE cycle publishes the assembled result
                  y         <= sr;
                  err       <= reserved;
                  out_valid <= 1'b1;
`ifdef SLU_PARITY_EN
                  parity    <= ^sr;
`endif
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
